mul_div_seq: RTL and testbench

Multi-cycle sequencer for the mult/div operations selected by the ALU control codes 4'b0011 (mult) and 4'b0100 (div).
- Accepts one operation at a time and runs an iterative shift-add multiply or restoring divide over WIDTH cycles.
- Holds results in HI/LO registers.
- Raises a stall to the pipeline while a result is pending and is requested, or while a new op arrives during a busy period.
- Sits beside the single-cycle ALU in EX; feeds mfhi/mflo read paths.

---
 rtl/mul_div_seq.sv | 124 ++++++++++++
 tb/tb_mul_div_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// Multi-cycle signed multiply / divide unit beside the EX-stage ALU.
// Runs WIDTH shift-add or restoring-divide iterations on operand magnitudes, then sign-corrects into HI/LO.
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             read_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam int         CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_b_q;
  logic               is_div_q, neg_q, a_neg_q, b_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic               done_q;

  logic               op_valid;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod_signed;

  assign op_valid = (op == OP_MULT) || (op == OP_DIV);

  // Multiply and divide share one 2W accumulator: the upper half is the partial
  // product / running remainder, the lower half the multiplier / dividend-quotient.
  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    div_trial   = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, mag_b_q};
    acc_d       = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_trial[WIDTH+1])
        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end

    prod_signed = neg_q ? -acc_q : acc_q;
    hi_d        = prod_signed[2*WIDTH-1:WIDTH];
    lo_d        = prod_signed[WIDTH-1:0];
    if (is_div_q) begin
      hi_d = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      lo_d = b_zero_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_b_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // flush squashes a start arriving in the same cycle
          if (!flush && start && op_valid) begin
            acc_q    <= {{WIDTH{1'b0}}, (a[WIDTH-1] ? -a : a)};
            mag_b_q  <= b[WIDTH-1] ? -b : b;
            is_div_q <= (op == OP_DIV);
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            a_neg_q  <= a[WIDTH-1];
            b_zero_q <= (b == '0);
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= SIGN;
          end
        end
        SIGN: begin
          if (!flush) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy & (read_req | start);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Randomized scoreboard bench for mul_div_seq: a driver queues expected HI/LO and
// issue cycle per accepted op; a monitor pops and compares on every done pulse.
module tb_mul_div_seq;

  localparam int         W       = 32;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;

  logic         clk = 1'b0;
  logic         rst_n, start, flush, read_req;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;

  mul_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .read_req(read_req), .busy(busy), .done(done),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: signed arithmetic in 64 bits; SV '/' truncates toward zero and '%' follows the dividend.
  function automatic logic [63:0] ref_model(input logic [3:0] opc, input logic [W-1:0] av, input logic [W-1:0] bv);
    longint p;
    int     sa, sb, q, r;
    sa = av;
    sb = bv;
    if (opc == OP_MULT) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    if (sb == 0)                   return {av, 32'hFFFF_FFFF};
    if (sa == 32'sh8000_0000 && sb == -1) return {32'h0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("latency", cyc - e.start_cyc, W + 1);
      end
    end
  end

  // Called at a negedge; returns at the following negedge with start dropped.
  task automatic issue(input logic [3:0] opc, input logic [W-1:0] av, input logic [W-1:0] bv, input bit expect_res);
    start = 1'b1; op = opc; a = av; b = bv;
    if (expect_res) begin
      exp_t e;
      logic [63:0] r;
      r = ref_model(opc, av, bv);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.start_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (done) return;
      @(negedge clk);
    end
    check("done_timeout", 1, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; read_req = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_idle", {busy, done, stall, hi, lo}, '0);
    end

    // mult 7 * -3 with busy-length count
    issue(OP_MULT, 32'd7, -32'sd3, 1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, W + 1);
    @(negedge clk);

    issue(OP_DIV, -32'sd17, 32'd5, 1);          wait_idle(); @(negedge clk);
    issue(OP_DIV, 32'd100, 32'd0, 1);           wait_idle(); @(negedge clk);
    issue(OP_DIV, 32'h8000_0000, -32'sd1, 1);   wait_idle(); @(negedge clk);

    // read_req held across the whole operation
    issue(OP_DIV, 32'd12345, 32'd67, 1);
    read_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (busy) begin
        check("stall_read_busy", stall, 1);
      end else begin
        check("done_with_read", done, 1);
        check("stall_read_done", stall, 0);
        break;
      end
      @(negedge clk);
    end
    read_req = 1'b0;
    @(negedge clk);

    // second start at counter 10 is ignored but stalls
    issue(OP_MULT, 32'd1000, 32'd999, 1);
    repeat (10) @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd50; b = 32'd7;
    #1 check("stall_start_busy", stall, 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    // start in the done cycle is accepted
    issue(OP_MULT, -32'sd5, -32'sd6, 1);
    wait_done();
    issue(OP_DIV, 32'd77, 32'd8, 1);
    check("accept_in_done", busy, 1);
    wait_idle();
    @(negedge clk);

    // flush at counter 20 keeps the prior result
    issue(OP_DIV, 32'd7, 32'd3, 1);
    wait_idle();
    @(negedge clk);
    issue(OP_MULT, 32'd5, 32'd9, 0);
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_state", {busy, hi, lo}, {1'b0, 32'd1, 32'd2});
    repeat (40) @(negedge clk);

    // flush in IDLE drops a simultaneous start
    flush = 1'b1;
    issue(OP_MULT, 32'd3, 32'd3, 0);
    flush = 1'b0;
    check("flush_idle_start", busy, 0);

    // asynchronous reset mid-CALC
    issue(OP_MULT, 32'd3, 32'd4, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_mid", {busy, done, stall, hi, lo}, '0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_mid_idle", busy, 0);
    repeat (40) @(negedge clk);

    issue(4'b0010, 32'd3, 32'd4, 0);
    check("invalid_op", busy, 0);
    @(negedge clk);
    check("invalid_op_hold", busy, 0);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [3:0]   ropc;
      logic [W-1:0] ra, rb;
      int           sel;
      ropc = $urandom_range(0, 1) ? OP_MULT : OP_DIV;
      sel  = $urandom_range(0, 9);
      ra   = (sel == 9) ? 32'h8000_0000 : $urandom;
      rb   = (sel == 0) ? 32'd0 : (sel == 1) ? -32'sd1 : (sel < 5) ? W'($urandom_range(1, 1000)) : $urandom;
      if ($urandom_range(0, 1)) ra = W'($signed(ra) >>> $urandom_range(0, 24));
      issue(ropc, ra, rb, 1);
      wait_idle();
      @(negedge clk);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
